// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the immediate extension pipe: mode encodings and the
// width-generic extend function used by the datapath.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    MODE_SIGN   = 2'b00,
    MODE_ZERO   = 2'b01,
    MODE_HIGH   = 2'b10,
    MODE_BRANCH = 2'b11
  } imm_mode_e;

  localparam int MAX_W = 64;

  // Widths are call arguments so one function serves any N/M/SHIFT; callers
  // pass constants, so the masks and shifts fold away in synthesis.
  function automatic logic [MAX_W-1:0] extend(input logic [1:0] mode,
                                              input logic [MAX_W-1:0] imm,
                                              input int n, input int m,
                                              input int shift);
    logic [MAX_W-1:0] nmask, mmask, lo, sx, sgn, r;
    nmask = '1;
    nmask = nmask >> (MAX_W - n);
    mmask = '1;
    mmask = mmask >> (MAX_W - m);
    lo    = imm & nmask;
    sgn   = imm >> (n - 1);
    sx    = sgn[0] ? (lo | ~nmask) : lo;
    case (mode)
      MODE_SIGN: r = sx;
      MODE_ZERO: r = lo;
      MODE_HIGH: r = lo << (m - n);
      default:   r = sx << shift;
    endcase
    return r & mmask;
  endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Valid/ready bus for the immediate extension pipe: request side from decode,
// response side toward the execute operand mux.
interface imm_extend_pipe_if #(
  parameter int N = 16,
  parameter int M = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   mode;
  logic [N-1:0] imm_in;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] imm_out;
  logic [1:0]   mode_out;

  modport master (
    output in_valid, mode, imm_in, out_ready,
    input  in_ready, out_valid, imm_out, mode_out
  );

  modport slave (
    input  in_valid, mode, imm_in, out_ready,
    output in_ready, out_valid, imm_out, mode_out
  );
endinterface

// File: rtl/imm_extend_pipe_reg.sv
// Generic valid/ready register stage with synchronous flush. Only the valid
// bit is reset; the payload register is free-running on load.
module imm_pipe_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             adv;

  always_comb begin
    adv     = !valid_q || out_ready;
    valid_d = valid_q;
    data_d  = data_q;
    // Flush wins over a load; the payload is irrelevant once valid drops.
    if (flush) begin
      valid_d = 1'b0;
    end else if (adv) begin
      valid_d = in_valid;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) valid_q <= 1'b0;
    else     valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign in_ready  = adv;
  assign out_valid = valid_q;
  assign out_data  = data_q;
endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate extender: stage A captures {mode, imm}, the extension is
// computed from A and registered into stage B, which drives the result bus.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int N     = 16,
  parameter int M     = 32,
  parameter int SHIFT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  imm_extend_pipe_if.slave    bus
);
  logic           a_ready, a_valid, b_ready;
  logic [N+1:0]   a_data;
  logic [M-1:0]   ext_res;
  logic [M+1:0]   b_data;

  // a_ready is !a_valid || b_ready, and b_ready depends on out_ready: this is
  // the one combinational path from the output side back to in_ready.
  assign bus.in_ready = a_ready && !flush;

  imm_pipe_reg #(.WIDTH(N + 2)) u_stage_a (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (bus.in_valid),
    .in_ready  (a_ready),
    .in_data   ({bus.mode, bus.imm_in}),
    .out_valid (a_valid),
    .out_ready (b_ready),
    .out_data  (a_data)
  );

  always_comb begin
    ext_res = M'(extend(a_data[N+1:N], {{(MAX_W-N){1'b0}}, a_data[N-1:0]},
                        N, M, SHIFT));
    b_data  = {a_data[N+1:N], ext_res};
  end

  imm_pipe_reg #(.WIDTH(M + 2)) u_stage_b (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (a_valid),
    .in_ready  (b_ready),
    .in_data   (b_data),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  ({bus.mode_out, bus.imm_out})
  );
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: directed vector table, multi-cycle corner cases,
// and random traffic checked by an in-order queue model at negedge.
module tb_imm_extend_pipe;
  logic clk = 1'b0;
  logic rst, flush;
  always #5 clk = ~clk;

  imm_extend_pipe_if #(.N(16), .M(32)) bus ();

  imm_extend_pipe #(.N(16), .M(32), .SHIFT(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  int          total = 0, bad = 0, rcvd = 0;
  logic [33:0] exp_q[$];
  bit          mon_en = 0, hold_pend = 0;
  logic [33:0] held;

  typedef struct {
    logic [1:0]  md;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] model(input logic [1:0] md, input logic [15:0] v);
    int s;
    s = int'($signed(v));
    case (md)
      2'b00:   return 32'(s);
      2'b01:   return 32'(v);
      2'b10:   return 32'(v) * 32'd65536;
      default: return 32'(s * 4);
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted beat queues its expected result; every
  // consumed result must match the head. rst/flush discard what is in flight.
  always @(negedge clk) begin
    if (mon_en) begin
      if (hold_pend)
        chk("hold", {bus.out_valid, bus.mode_out, bus.imm_out}, {1'b1, held});
      hold_pend = bus.out_valid && !bus.out_ready && !rst && !flush;
      held      = {bus.mode_out, bus.imm_out};
      if (bus.out_valid && bus.out_ready) begin
        chk("out_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0)
          chk("out_data", {bus.mode_out, bus.imm_out}, exp_q.pop_front());
        rcvd++;
      end
      if (flush) chk("flush_ready", bus.in_ready, 0);
      if (rst || flush) exp_q.delete();
      else if (bus.in_valid && bus.in_ready)
        exp_q.push_back({bus.mode, model(bus.mode, bus.imm_in)});
    end
  end

  initial begin
    vec_t tbl[7];
    int   r0, b;
    bit   saw_full, pend;

    tbl[0] = '{2'b00, 16'h8001, 32'hFFFF8001};
    tbl[1] = '{2'b01, 16'h8001, 32'h00008001};
    tbl[2] = '{2'b10, 16'h8001, 32'h80010000};
    tbl[3] = '{2'b11, 16'h8001, 32'hFFFE0004};
    tbl[4] = '{2'b11, 16'h7FFF, 32'h0001FFFC};
    tbl[5] = '{2'b11, 16'hFFFF, 32'hFFFFFFFC};
    tbl[6] = '{2'b11, 16'h0000, 32'h00000000};

    rst = 1'b1; flush = 1'b0;
    bus.in_valid = 1'b0; bus.mode = 2'b00; bus.imm_in = '0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    step();
    mon_en = 1;

    // Directed vectors, one at a time, checking two-edge latency.
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1; bus.mode = tbl[i].md; bus.imm_in = tbl[i].imm;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("tbl_in_ready", bus.in_ready, 1);
      step();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("tbl_early", bus.out_valid, 0);
      step();
      @(negedge clk);
      chk("tbl_valid", bus.out_valid, 1);
      chk("tbl_data", bus.imm_out, tbl[i].exp);
      chk("tbl_mode", bus.mode_out, tbl[i].md);
      step();
    end

    // Backpressure: 8 beats, consumer stalls for cycles 3..6.
    b = 0; saw_full = 0; r0 = rcvd;
    for (int c = 0; c < 40; c++) begin
      bus.out_ready = !(c >= 3 && c <= 6);
      bus.in_valid  = (b < 8);
      bus.mode      = 2'(b);
      bus.imm_in    = 16'h1000 + 16'(b);
      @(negedge clk);
      if (bus.in_valid && !bus.in_ready && !bus.out_ready) saw_full = 1;
      if (bus.in_valid && bus.in_ready) b++;
      step();
      if (b == 8 && rcvd - r0 == 8) break;
    end
    bus.in_valid = 1'b0;
    chk("bp_full_seen", 64'(saw_full), 1);
    chk("bp_count", 64'(rcvd - r0), 8);
    chk("bp_drained", 64'(exp_q.size()), 0);

    // Flush with both stages full and the consumer stalled.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.mode = 2'b01; bus.imm_in = 16'hAAAA;
    step();
    bus.mode = 2'b00; bus.imm_in = 16'h5555;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("fl_full_ready", bus.in_ready, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_out_valid", bus.out_valid, 0);
    chk("fl_in_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.mode = 2'b00; bus.imm_in = 16'h1234; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("fl_first", {bus.out_valid, bus.imm_out}, {1'b1, 32'h00001234});
    step();

    // Reset mid-stream with in_valid held high.
    bus.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus.in_valid = 1'b1; bus.mode = 2'(j); bus.imm_in = 16'($urandom);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", bus.out_valid, 0);
    r0 = rcvd;
    step();
    for (int j = 0; j < 3; j++) begin
      bus.in_valid = 1'b1; bus.mode = 2'(j + 1); bus.imm_in = 16'($urandom);
      step();
    end
    bus.in_valid = 1'b0;
    repeat (3) step();
    chk("rst_restart_count", 64'(rcvd - r0), 3);

    // Random traffic, holding a pending beat stable until accepted.
    pend = 0; r0 = rcvd;
    for (int c = 0; c < 10000; c++) begin
      if (!pend) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.mode     = 2'($urandom);
        bus.imm_in   = 16'($urandom);
      end
      bus.out_ready = ($urandom_range(0, 3) != 0);
      flush         = ($urandom_range(0, 63) == 0);
      rst           = ($urandom_range(0, 255) == 0);
      @(negedge clk);
      pend = bus.in_valid && !bus.in_ready;
      step();
    end
    rst = 1'b0; flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (4) step();
    chk("rand_drain", 64'(exp_q.size()), 0);
    chk("rand_progress", 64'(rcvd - r0 > 2000), 1);

    mon_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
